// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Definitions shared by the BIST pattern generator and the output response
// analyser: controller state encoding, MISR width, feedback taps, seed value
// and counter widths.
// No ports (package).
// -----------------------------------------------------------------------------
package bist_pkg;

   localparam int MISR_W = 3;

   // x^3 + x + 1: when the MSB shifts out it folds back into bits 1 and 0.
   localparam logic [MISR_W-1:0] MISR_TAPS = 3'b011;

   // Value the signature register starts each session from.
   localparam logic [MISR_W-1:0] MISR_SEED = 3'b000;

   // Vector counter (responses per session) and watchdog cycle counter.
   localparam int CNT_W = 4;
   localparam int CYC_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } bist_state_e;

endpackage : bist_pkg

// File: rtl/bist_misr3.sv
// -----------------------------------------------------------------------------
// bist_misr3
// 3-bit multiple-input signature register, polynomial x^3 + x + 1, written in
// Galois form: shift up by one, fold the outgoing MSB into the tap bits, then
// XOR in the response word.
// Ports:
//   clock    in   clock
//   reset    in   asynchronous active-low reset (register -> 000)
//   clr      in   reload the seed value (takes priority over en)
//   en       in   compress resp_in this cycle
//   resp_in  in   2-bit response {carry, sum}
//   sig      out  current signature
// -----------------------------------------------------------------------------
module bist_misr3
   import bist_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic [1:0]        resp_in,
   output logic [MISR_W-1:0] sig
);

   logic [MISR_W-1:0] sig_q, sig_d;
   logic [MISR_W-1:0] shifted;
   logic [MISR_W-1:0] r_ext;

   always_comb begin
      r_ext   = {{(MISR_W-2){1'b0}}, resp_in};
      // Expands to s0'=s2^r0, s1'=s0^s2^r1, s2'=s1.
      shifted = {sig_q[MISR_W-2:0], 1'b0} ^ (MISR_TAPS & {MISR_W{sig_q[MISR_W-1]}});
      sig_d   = sig_q;
      if (clr)
         sig_d = MISR_SEED;
      else if (en)
         sig_d = shifted ^ r_ext;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         sig_q <= '0;
      else
         sig_q <= sig_d;
   end

   assign sig = sig_q;

endmodule : bist_misr3

// File: rtl/bist_ora_misr.sv
// -----------------------------------------------------------------------------
// bist_ora_misr
// Output response analyser: compresses N_VECTORS accepted CUT responses into a
// 3-bit MISR, compares the final signature with GOLDEN_SIG and reports the
// result. Controller: IDLE -> RUN -> COMPARE -> DONE.
// Optional feature: define BIST_ORA_TIMEOUT_EN to add a RUN-state watchdog that
// aborts the session to DONE (pass=0, timeout=1) after TIMEOUT_CYCLES cycles.
// Without it, timeout is tied low and RUN waits indefinitely.
// Ports:
//   clock       in   clock, all state changes on posedge
//   reset       in   asynchronous active-low reset
//   start       in   one-cycle pulse, starts a session from IDLE or DONE
//   resp_in     in   CUT response {carry, sum}
//   resp_valid  in   resp_in valid this cycle
//   signature   out  current MISR contents
//   busy        out  high in RUN and COMPARE
//   done        out  high in DONE
//   pass        out  signature matched GOLDEN_SIG (meaningful while done=1)
//   timeout     out  session aborted by the watchdog
// -----------------------------------------------------------------------------
module bist_ora_misr
   import bist_pkg::*;
#(
   parameter logic [MISR_W-1:0] GOLDEN_SIG     = 3'b000,
   parameter int                N_VECTORS      = 7,
   parameter int                TIMEOUT_CYCLES = 31
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        resp_in,
   input  logic              resp_valid,
   output logic [MISR_W-1:0] signature,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout
);

   if (N_VECTORS < 1 || N_VECTORS > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 31) begin : g_bad_cfg
      $error("bist_ora_misr: N_VECTORS must be 1..15 and TIMEOUT_CYCLES 1..31");
   end

   // Count value held when the final response arrives.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_VECTORS - 1);

   bist_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pass_q, pass_d;
   logic              misr_clr, misr_en;
   logic              last_resp;
   logic [MISR_W-1:0] sig;

`ifdef BIST_ORA_TIMEOUT_EN
   // Cycle-counter value during the final allowed RUN cycle.
   localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(TIMEOUT_CYCLES - 1);

   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic             to_q, to_d;
`endif

   bist_misr3 u_misr (
      .clock   (clock),
      .reset   (reset),
      .clr     (misr_clr),
      .en      (misr_en),
      .resp_in (resp_in),
      .sig     (sig)
   );

   assign last_resp = resp_valid && (cnt_q == LAST_CNT);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pass_d   = pass_q;
      misr_clr = 1'b0;
      misr_en  = 1'b0;
`ifdef BIST_ORA_TIMEOUT_EN
      cyc_d    = cyc_q;
      to_d     = to_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_RUN;
               cnt_d    = '0;
               pass_d   = 1'b0;
               misr_clr = 1'b1;
`ifdef BIST_ORA_TIMEOUT_EN
               cyc_d    = '0;
               to_d     = 1'b0;
`endif
            end
         end
         ST_RUN: begin
            if (resp_valid) begin
               misr_en = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (last_resp)
                  state_d = ST_COMPARE;
            end
`ifdef BIST_ORA_TIMEOUT_EN
            // Completing the session on this edge wins over the watchdog.
            if (!last_resp) begin
               if (cyc_q == LAST_CYC) begin
                  state_d = ST_DONE;
                  to_d    = 1'b1;
                  pass_d  = 1'b0;
               end else begin
                  cyc_d = cyc_q + 1'b1;
               end
            end
`endif
         end
         ST_COMPARE: begin
            pass_d  = (sig == GOLDEN_SIG);
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
      end
   end

`ifdef BIST_ORA_TIMEOUT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cyc_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cyc_q <= cyc_d;
         to_q  <= to_d;
      end
   end

   assign timeout = to_q;
`else
   assign timeout = 1'b0;
`endif

   assign signature = sig;
   assign busy      = (state_q == ST_RUN) || (state_q == ST_COMPARE);
   assign done      = (state_q == ST_DONE);
   assign pass      = pass_q;

endmodule : bist_ora_misr

// File: tb/tb_bist_ora_misr.sv
// -----------------------------------------------------------------------------
// tb_bist_ora_misr
// Two analysers (golden 101 and golden 000) share one stimulus stream. A
// behavioural model treats the signature as a polynomial over GF(2) that is
// multiplied by x modulo x^3+x+1 per accepted response; the compare process
// checks every output of both instances on every falling edge.
// -----------------------------------------------------------------------------
module tb_bist_ora_misr;

   localparam logic [2:0] GA = 3'b101;
   localparam logic [2:0] GB = 3'b000;
   localparam int NV = 7;
   localparam int TO = 31;

   localparam int M_IDLE = 0, M_RUN = 1, M_CMP = 2, M_DONE = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       resp_valid = 1'b0;
   logic [1:0] resp_in = 2'b00;

   logic [2:0] sig_a, sig_b;
   logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, to_a, to_b;

   int checks = 0;
   int errors = 0;
   bit auto_en = 1'b0;

   always #5 clock = ~clock;

   bist_ora_misr #(.GOLDEN_SIG(GA), .N_VECTORS(NV), .TIMEOUT_CYCLES(TO)) u_dut_a (
      .clock(clock), .reset(reset), .start(start), .resp_in(resp_in),
      .resp_valid(resp_valid), .signature(sig_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .timeout(to_a)
   );

   bist_ora_misr #(.GOLDEN_SIG(GB), .N_VECTORS(NV), .TIMEOUT_CYCLES(TO)) u_dut_b (
      .clock(clock), .reset(reset), .start(start), .resp_in(resp_in),
      .resp_valid(resp_valid), .signature(sig_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .timeout(to_b)
   );

   // Signature as a polynomial: multiply by x, reduce by x^3+x+1, add response.
   function automatic logic [2:0] misr_step(input logic [2:0] s, input logic [1:0] r);
      logic [3:0] p;
      p = {s, 1'b0};
      if (p[3]) p = p ^ 4'b1011;
      return p[2:0] ^ {1'b0, r};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   int         m_mode = M_IDLE;
   logic [2:0] m_sig = 3'b000;
   int         m_cnt = 0;
   int         m_run = 0;
   bit         m_pass_a = 1'b0, m_pass_b = 1'b0, m_to = 1'b0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_mode = M_IDLE; m_sig = 3'b000; m_cnt = 0; m_run = 0;
         m_pass_a = 1'b0; m_pass_b = 1'b0; m_to = 1'b0;
      end else begin
         case (m_mode)
            M_IDLE, M_DONE: if (start) begin
               m_mode = M_RUN; m_sig = 3'b000; m_cnt = 0; m_run = 0;
               m_pass_a = 1'b0; m_pass_b = 1'b0; m_to = 1'b0;
            end
            M_RUN: begin
               m_run++;
               if (resp_valid) begin
                  m_sig = misr_step(m_sig, resp_in);
                  m_cnt++;
               end
               if (resp_valid && m_cnt == NV) m_mode = M_CMP;
`ifdef BIST_ORA_TIMEOUT_EN
               else if (m_run == TO) begin
                  m_mode = M_DONE; m_to = 1'b1; m_pass_a = 1'b0; m_pass_b = 1'b0;
               end
`endif
            end
            M_CMP: begin
               m_pass_a = (m_sig == GA);
               m_pass_b = (m_sig == GB);
               m_mode = M_DONE;
            end
            default: m_mode = M_IDLE;
         endcase
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clock) begin
      if (auto_en) begin
         chk("sig_a", 32'(sig_a), 32'(m_sig));
         chk("sig_b", 32'(sig_b), 32'(m_sig));
         chk("busy_a", 32'(busy_a), 32'(m_mode == M_RUN || m_mode == M_CMP));
         chk("busy_b", 32'(busy_b), 32'(m_mode == M_RUN || m_mode == M_CMP));
         chk("done_a", 32'(done_a), 32'(m_mode == M_DONE));
         chk("done_b", 32'(done_b), 32'(m_mode == M_DONE));
         chk("timeout_a", 32'(to_a), 32'(m_to));
         chk("timeout_b", 32'(to_b), 32'(m_to));
         if (m_mode == M_DONE || m_mode == M_IDLE) begin
            chk("pass_a", 32'(pass_a), 32'(m_pass_a));
            chk("pass_b", 32'(pass_b), 32'(m_pass_b));
         end
      end
   end

   // One session: start pulse, NV accepted responses (optionally with random
   // gaps and ignored start pulses), then wait (bounded) for done.
   task automatic session(input logic [13:0] rv, input int gap_max, input bit noise,
                          output int cyc, output logic [20:0] hist);
      start = 1'b1;
      tick();
      cyc = 1;
      start = 1'b0;
      hist = '0;
      for (int i = 0; i < NV; i++) begin
         int g;
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         for (int k = 0; k < g; k++) begin
            resp_valid = 1'b0;
            resp_in = 2'($urandom);
            start = noise ? 1'($urandom) : 1'b0;
            tick();
            cyc++;
         end
         start = 1'b0;
         resp_valid = 1'b1;
         resp_in = rv[2*i +: 2];
         tick();
         cyc++;
         hist[3*i +: 3] = sig_a;
      end
      resp_valid = 1'b0;
      start = 1'b0;
      while (!done_a && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("session_done", 32'(done_a), 32'd1);
   endtask

   initial begin
      int         cyc;
      logic [20:0] hist;
      logic [13:0] rv;
      logic [2:0]  exp_sig;

      // Reset state
      reset = 1'b0;
      tick();
      auto_en = 1'b1;
      tick();
      chk("rst_sig", 32'(sig_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_pass", 32'(pass_a), 32'd0);
      chk("rst_timeout", 32'(to_a), 32'd0);
      reset = 1'b1;
      tick();

      // Pin the model's step function with hand-computed values
      chk("model_step0", 32'(misr_step(3'b000, 2'b01)), 32'h1);
      chk("model_step1", 32'(misr_step(3'b101, 2'b00)), 32'h1);
      chk("model_step2", 32'(misr_step(3'b011, 2'b10)), 32'h4);

      // All-zero responses, golden 000
      session(14'b0, 0, 1'b0, cyc, hist);
      chk("zero_latency", 32'(cyc), 32'd9);
      chk("zero_sig", 32'(sig_b), 32'd0);
      chk("zero_pass_b", 32'(pass_b), 32'd1);
      chk("zero_pass_a", 32'(pass_a), 32'd0);

      // resp_valid in DONE is ignored
      resp_valid = 1'b1;
      resp_in = 2'b11;
      repeat (3) tick();
      resp_valid = 1'b0;
      chk("done_hold_sig", 32'(sig_b), 32'd0);
      chk("done_hold_done", 32'(done_b), 32'd1);

      // Responses 01,00,...: known signature trajectory
      session(14'b00_0000_0000_0001, 0, 1'b0, cyc, hist);
      chk("seq_hist", 32'(hist), 32'({3'b101, 3'b111, 3'b110, 3'b011, 3'b100, 3'b010, 3'b001}));
      chk("seq_pass_a", 32'(pass_a), 32'd1);
      chk("seq_pass_b", 32'(pass_b), 32'd0);
      chk("seq_done_b", 32'(done_b), 32'd1);

      // Same responses with gaps and start noise
      session(14'b00_0000_0000_0001, 3, 1'b1, cyc, hist);
      chk("gap_sig", 32'(sig_a), 32'h5);
      chk("gap_pass_a", 32'(pass_a), 32'd1);

      // Mid-session asynchronous reset after 3 responses
      start = 1'b1;
      tick();
      start = 1'b0;
      resp_valid = 1'b1;
      resp_in = 2'b01;
      repeat (3) tick();
      resp_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("arst_sig", 32'(sig_a), 32'd0);
      chk("arst_busy", 32'(busy_a), 32'd0);
      chk("arst_done", 32'(done_a), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      session(14'b00_0000_0000_0001, 0, 1'b0, cyc, hist);
      chk("post_rst_sig", 32'(sig_a), 32'h5);
      chk("post_rst_pass", 32'(pass_a), 32'd1);

`ifdef BIST_ORA_TIMEOUT_EN
      // Watchdog: no responses at all
      start = 1'b1;
      tick();
      cyc = 1;
      start = 1'b0;
      while (!done_a && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("wd_latency", 32'(cyc), 32'd32);
      chk("wd_timeout", 32'(to_a), 32'd1);
      chk("wd_pass", 32'(pass_a), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("wd_clear", 32'(to_a), 32'd0);
      chk("wd_busy", 32'(busy_a), 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
`endif

      // Randomized sessions, occasionally preceded by an aborted one
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(4, 0) == 0) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat ($urandom_range(5, 1)) begin
               resp_valid = 1'($urandom);
               resp_in = 2'($urandom);
               tick();
            end
            resp_valid = 1'b0;
            #2 reset = 1'b0;
            tick();
            reset = 1'b1;
            tick();
         end
         rv = 14'($urandom);
         session(rv, 3, 1'b1, cyc, hist);
         exp_sig = 3'b000;
         for (int i = 0; i < NV; i++) exp_sig = misr_step(exp_sig, rv[2*i +: 2]);
         chk("rand_sig", 32'(sig_a), 32'(exp_sig));
         chk("rand_pass_a", 32'(pass_a), 32'(exp_sig == GA));
         chk("rand_pass_b", 32'(pass_b), 32'(exp_sig == GB));
         repeat ($urandom_range(3, 0)) begin
            resp_valid = 1'($urandom);
            resp_in = 2'($urandom);
            tick();
         end
         resp_valid = 1'b0;
      end

      tick();
      auto_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_bist_ora_misr

// File: doc/bist_ora_misr.md
BIST_ORA_MISR -- requirements
Module: bist_ora_misr

Interface
REQ-001 SHALL have parameter GOLDEN_SIG, default 3'b000: expected final signature.
REQ-002 SHALL have parameter N_VECTORS, default 7: responses compressed per session (range 1..15).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 31: RUN-state cycle limit (used only under REQ-025).
REQ-004 clock  input  1  single clock; all state changes on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins a session.
REQ-007 resp_in  input  2  CUT response {carry, sum}.
REQ-008 resp_valid  input  1  resp_in valid this cycle.
REQ-009 signature  output  3  current MISR contents.
REQ-010 busy  output  1  high in RUN and COMPARE.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  comparison result; meaningful only while done=1.
REQ-013 timeout  output  1  session aborted by watchdog.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> COMPARE -> DONE.
REQ-015 IDLE: start=1 SHALL clear signature to 3'b000 and the vector count to 0, and enter RUN.
REQ-016 RUN: each cycle with resp_valid=1 SHALL update the MISR (polynomial x^3+x+1): s0'=s2^r0, s1'=s0^s2^r1, s2'=s1, with r=resp_in; it SHALL then increment the count.
REQ-017 RUN: resp_valid=0 SHALL hold signature and count.
REQ-018 The accepted response that brings the count to N_VECTORS SHALL be compressed and SHALL move the FSM to COMPARE on the same edge. Further resp_valid pulses SHALL be ignored.
REQ-019 COMPARE SHALL last exactly one cycle: pass <= (signature==GOLDEN_SIG); then enter DONE.
REQ-020 DONE: done=1, and signature and pass SHALL hold. start=1 SHALL behave as in REQ-015, with done deasserting the next cycle.
REQ-021 start in RUN or COMPARE SHALL be ignored.
REQ-022 resp_valid in IDLE or DONE SHALL be ignored.
REQ-023 The count register SHALL be 4 bits and SHALL never wrap within a session.

Reset
REQ-024 reset=0 SHALL, asynchronously in any state, force IDLE, signature=000, count=0, busy=0, done=0, pass=0 and timeout=0. A mid-session reset SHALL discard all partial state.

Configuration
REQ-025 With BIST_ORA_TIMEOUT_EN defined: a 5-bit cycle counter SHALL run in RUN. On reaching TIMEOUT_CYCLES before REQ-018 fires, the FSM SHALL go directly to DONE with pass=0 and timeout=1. timeout SHALL clear on the next start.
REQ-026 Without BIST_ORA_TIMEOUT_EN: no watchdog logic; timeout SHALL be tied 0; RUN SHALL wait indefinitely.

Structure
REQ-027 A shared package bist_pkg SHALL hold the FSM state enum, MISR width (3), polynomial taps and the seed constant. The TPG and ORA SHALL share these definitions.
REQ-028 The MISR register and next-state equations SHALL form one sub-module, bist_misr3. The FSM and counters SHALL remain in bist_ora_misr.

Verification
REQ-029 start, then 7 valid responses of 2'b00, GOLDEN_SIG=000 -> signature=000; done=1 at cycle 9 after start; pass=1.
REQ-030 start, then responses 01,00,00,00,00,00,00 -> signature sequence 001,010,100,011,110,111,101; with GOLDEN_SIG=101, pass=1.
REQ-031 Same stimulus as REQ-030 with GOLDEN_SIG=000 -> pass=0, done=1.
REQ-032 Responses with resp_valid gaps -> same final signature as the gap-free run; start pulses during RUN have no effect.
REQ-033 reset asserted after 3 responses -> signature=000, done=0 and busy=0 immediately; a new session then produces correct results.
REQ-034 With BIST_ORA_TIMEOUT_EN defined: start, then no resp_valid -> after 31 RUN cycles done=1, timeout=1, pass=0.
